// File: rtl/ff_exc_pkg.sv
// rtl/ff_exc_pkg.sv - shared codes, bit indices and FSM encoding for ff_excitation_encoder
package ff_exc_pkg;

  localparam logic [1:0] CODE_HOLD = 2'b00;
  localparam logic [1:0] CODE_01   = 2'b01;
  localparam logic [1:0] CODE_10   = 2'b10;
  localparam logic [1:0] CODE_11   = 2'b11;

  localparam int IDX_SR = 0;
  localparam int IDX_JK = 1;
  localparam int IDX_D  = 2;
  localparam int IDX_T  = 3;

  typedef enum logic {
    UNINIT = 1'b0,
    RUN    = 1'b1
  } enc_state_t;

endpackage

// File: rtl/ff_exc_select.sv
// rtl/ff_exc_select.sv - combinational per-word excitation code chooser
// Optional macro FFENC_JK_TOGGLE_EN: use JK toggle (11) for a known-state change.
module ff_exc_select
  import ff_exc_pkg::*;
(
  input  logic [3:0] q,
  input  logic [3:0] tgt,
  input  logic       uninit,
  output logic [1:0] sr_code,
  output logic [1:0] jk_code,
  output logic [1:0] d_code,
  output logic [1:0] t_code
);

  logic t_present;

  always_comb begin
    sr_code   = CODE_HOLD;
    jk_code   = CODE_HOLD;
    d_code    = CODE_HOLD;
    t_code    = CODE_HOLD;
    t_present = uninit ? 1'b0 : q[IDX_T];

    // Unknown power-up state: only an explicit set/reset is safe.
    if (uninit || (tgt[IDX_SR] != q[IDX_SR]))
      sr_code = tgt[IDX_SR] ? CODE_01 : CODE_10;

    if (uninit) begin
      jk_code = tgt[IDX_JK] ? CODE_10 : CODE_01;
    end else if (tgt[IDX_JK] != q[IDX_JK]) begin
`ifdef FFENC_JK_TOGGLE_EN
      jk_code = CODE_11;
`else
      jk_code = tgt[IDX_JK] ? CODE_10 : CODE_01;
`endif
    end

    d_code = tgt[IDX_D] ? CODE_01 : CODE_HOLD;

    if (tgt[IDX_T] != t_present)
      t_code = CODE_01;
  end

endmodule

// File: rtl/ff_excitation_encoder.sv
// rtl/ff_excitation_encoder.sv - target-state to flip-flop excitation code encoder, valid/ready stream
// Optional macro FFENC_JK_TOGGLE_EN (see ff_exc_select).
module ff_excitation_encoder
  import ff_exc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [3:0]       tgt,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [1:0]       sr_code,
  output logic [1:0]       jk_code,
  output logic [1:0]       d_code,
  output logic [1:0]       t_code,
  output logic [3:0]       q_model,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  enc_state_t state;
  enc_state_t state_next;
  logic       accept;
  logic [1:0] sel_sr;
  logic [1:0] sel_jk;
  logic [1:0] sel_d;
  logic [1:0] sel_t;

  assign tgt_ready = !code_valid || code_ready;
  assign accept    = tgt_valid && tgt_ready;

  ff_exc_select u_select (
    .q       (q_model),
    .tgt     (tgt),
    .uninit  (state == UNINIT),
    .sr_code (sel_sr),
    .jk_code (sel_jk),
    .d_code  (sel_d),
    .t_code  (sel_t)
  );

  always_comb begin
    state_next = state;
    if (accept)
      state_next = RUN;
  end

  // A consume without a new accept leaves the codes in place; only valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= UNINIT;
      code_valid <= 1'b0;
      sr_code    <= CODE_HOLD;
      jk_code    <= CODE_HOLD;
      d_code     <= CODE_HOLD;
      t_code     <= CODE_HOLD;
      q_model    <= 4'b0000;
      issued_cnt <= '0;
      toggle_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        code_valid <= 1'b1;
        sr_code    <= sel_sr;
        jk_code    <= sel_jk;
        d_code     <= sel_d;
        t_code     <= sel_t;
        q_model    <= tgt;
        issued_cnt <= issued_cnt + CNT_W'(1);
        if (sel_t == CODE_01)
          toggle_cnt <= toggle_cnt + CNT_W'(1);
      end else if (code_ready) begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ff_excitation_encoder.sv
// tb/tb_ff_excitation_encoder.sv - self-checking bench: vector table, scoreboard, closed-loop flop model
module tb_ff_excitation_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [3:0] tgt;
  logic       code_valid;
  logic       code_ready;
  logic [1:0] sr_code, jk_code, d_code, t_code;
  logic [3:0] q_model;
  logic [7:0] issued_cnt, toggle_cnt;

  logic       tgt_ready2, code_valid2;
  logic [1:0] sr_code2, jk_code2, d_code2, t_code2;
  logic [3:0] q_model2;
  logic [1:0] issued_cnt2, toggle_cnt2;

  always #5 clk = ~clk;

  ff_excitation_encoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt(tgt),
    .code_valid(code_valid), .code_ready(code_ready), .sr_code(sr_code), .jk_code(jk_code),
    .d_code(d_code), .t_code(t_code), .q_model(q_model), .issued_cnt(issued_cnt),
    .toggle_cnt(toggle_cnt)
  );

  ff_excitation_encoder #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready2), .tgt(tgt),
    .code_valid(code_valid2), .code_ready(code_ready), .sr_code(sr_code2), .jk_code(jk_code2),
    .d_code(d_code2), .t_code(t_code2), .q_model(q_model2), .issued_cnt(issued_cnt2),
    .toggle_cnt(toggle_cnt2)
  );

`ifdef FFENC_JK_TOGGLE_EN
  localparam logic [1:0] JK_DN = 2'b11;
  localparam logic [1:0] JK_UP = 2'b11;
`else
  localparam logic [1:0] JK_DN = 2'b01;
  localparam logic [1:0] JK_UP = 2'b10;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] sr, jk, d, t;
    logic [3:0] q;
    int         iss;
    int         tog;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] mq;
  bit         mun;
  int         miss, mtog;
  logic [3:0] fl;

  function automatic logic [7:0] enc(input logic [3:0] q, input logic [3:0] t, input bit un);
    logic [1:0] sr, jk, d, tc;
    logic       tq;
    sr = (un || t[0] != q[0]) ? (t[0] ? 2'b01 : 2'b10) : 2'b00;
    if (un)               jk = t[1] ? 2'b10 : 2'b01;
    else if (t[1] == q[1]) jk = 2'b00;
    else                  jk = t[1] ? JK_UP : JK_DN;
    d  = {1'b0, t[2]};
    tq = un ? 1'b0 : q[3];
    tc = (t[3] != tq) ? 2'b01 : 2'b00;
    return {tc, d, jk, sr};
  endfunction

  // Scoreboard plus behavioural flop bank fed by consumed bundles.
  initial begin
    exp_t       e;
    logic [7:0] c;
    fl = {1'b0, 3'($urandom_range(0, 7))};
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        sbq.delete();
        mq = 4'b0; mun = 1'b1; miss = 0; mtog = 0; fl[3] = 1'b0;
      end else begin
        if (code_valid && code_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_bundle", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("sb_sr", sr_code, e.sr);
            check("sb_jk", jk_code, e.jk);
            check("sb_d", d_code, e.d);
            check("sb_t", t_code, e.t);
            check("sb_q_model", q_model, e.q);
            check("sb_issued", issued_cnt, e.iss % 256);
            check("sb_toggle", toggle_cnt, e.tog % 256);
            check("sb_issued_w2", issued_cnt2, e.iss % 4);
            check("sb_toggle_w2", toggle_cnt2, e.tog % 4);
            check("sr_not_11", sr_code == 2'b11, 32'd0);
            case (sr_code)
              2'b01: fl[0] = 1'b1;
              2'b10: fl[0] = 1'b0;
              2'b11: fl[0] = 1'bx;
              default: ;
            endcase
            case (jk_code)
              2'b01: fl[1] = 1'b0;
              2'b10: fl[1] = 1'b1;
              2'b11: fl[1] = ~fl[1];
              default: ;
            endcase
            fl[2] = d_code[0];
            if (t_code[0]) fl[3] = ~fl[3];
            check("flop_states", fl, e.q);
          end
        end
        if (tgt_valid && tgt_ready) begin
          c = enc(mq, tgt, mun);
          miss++;
          if (c[7:6] == 2'b01) mtog++;
          e.sr = c[1:0]; e.jk = c[3:2]; e.d = c[5:4]; e.t = c[7:6];
          e.q = tgt; e.iss = miss; e.tog = mtog;
          sbq.push_back(e);
          mq  = tgt;
          mun = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] tgt;
    logic [1:0] sr, jk, d, t;
    int         tog;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] held;
    int         acc;
    vecs[0] = '{4'b0000, 2'b10, 2'b01, 2'b00, 2'b00, 0};
    vecs[1] = '{4'b1111, 2'b01, 2'b10, 2'b01, 2'b01, 1};
    vecs[2] = '{4'b1111, 2'b00, 2'b00, 2'b01, 2'b00, 1};
    vecs[3] = '{4'b0000, 2'b10, JK_DN, 2'b00, 2'b01, 2};
    vecs[4] = '{4'b0101, 2'b01, 2'b00, 2'b01, 2'b00, 2};
    vecs[5] = '{4'b1010, 2'b10, JK_UP, 2'b00, 2'b01, 3};

    rst_n = 1'b0; tgt_valid = 1'b0; tgt = 4'b0; code_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst_code_valid", code_valid, 32'd0);
    check("rst_codes", {sr_code, jk_code, d_code, t_code}, 32'd0);
    check("rst_q_model", q_model, 32'd0);
    check("rst_issued", issued_cnt, 32'd0);
    check("rst_toggle", toggle_cnt, 32'd0);
    check("rst_tgt_ready", tgt_ready, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      tgt_valid = 1'b1;
      tgt = vecs[i].tgt;
      @(negedge clk);
      #2;
      check("vec_valid", code_valid, 32'd1);
      check("vec_sr", sr_code, vecs[i].sr);
      check("vec_jk", jk_code, vecs[i].jk);
      check("vec_d", d_code, vecs[i].d);
      check("vec_t", t_code, vecs[i].t);
      check("vec_q_model", q_model, vecs[i].tgt);
      check("vec_issued", issued_cnt, i + 1);
      check("vec_toggle", toggle_cnt, vecs[i].tog);
    end

    // Back-pressure: bundle for 1010 held for three cycles, then drained with no bubble.
    code_ready = 1'b0;
    tgt = 4'b0110;
    held = {sr_code, jk_code, d_code, t_code};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check("bp_tgt_ready", tgt_ready, 32'd0);
      check("bp_codes_frozen", {sr_code, jk_code, d_code, t_code}, held);
      check("bp_issued", issued_cnt, 32'd6);
      check("bp_valid", code_valid, 32'd1);
    end
    code_ready = 1'b1;
    #1;
    check("bp_release_ready", tgt_ready, 32'd1);
    @(negedge clk);
    #2;
    check("bp_next_issued", issued_cnt, 32'd7);
    check("bp_next_valid", code_valid, 32'd1);
    check("bp_next_q", q_model, 32'h6);
    check("bp_next_codes", {sr_code, jk_code, d_code, t_code}, {2'b00, 2'b00, 2'b01, 2'b01});

    // Reset while a bundle is held.
    code_ready = 1'b0;
    tgt = 4'b1001;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check("mid_rst_valid", code_valid, 32'd0);
    check("mid_rst_q", q_model, 32'd0);
    check("mid_rst_issued", issued_cnt, 32'd0);
    check("mid_rst_toggle", toggle_cnt, 32'd0);
    check("mid_rst_issued_w2", issued_cnt2, 32'd0);
    rst_n = 1'b1;
    code_ready = 1'b1;
    tgt = 4'b0000;
    @(negedge clk);
    #2;
    check("uninit_sr_explicit", sr_code, 32'h2);
    check("uninit_jk_explicit", jk_code, 32'h1);
    check("uninit_issued", issued_cnt, 32'd1);

    // Closed loop: random targets, random valid/ready, bounded cycle count.
    acc = 0;
    for (int cyc = 0; cyc < 3000 && acc < 300; cyc++) begin
      tgt        = 4'($urandom_range(0, 15));
      tgt_valid  = ($urandom_range(0, 3) != 0);
      code_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (tgt_valid && tgt_ready) acc++;
      @(negedge clk);
      #2;
    end
    check("random_accepts", acc, 32'd300);

    tgt_valid  = 1'b0;
    code_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("drain_queue_empty", sbq.size(), 32'd0);
    check("drain_valid", code_valid, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
